tap_ctrl: RTL and testbench
===========================

# tap_ctrl

IEEE 1149.1 TAP controller and instruction register for the JTAG core. It sits directly upstream of the data-register block. It runs the 16-state TAP FSM from TMS and drives that block's CAPTUREDR/SHIFTDR/UPDATEDR strobes. It holds and decodes a 4-bit instruction into the one-hot *_SELECT lines. It also muxes the per-register TDO bits, plus an internal bypass bit, onto the chip TDO pin.

## Interface
- IR_WIDTH, 4: instruction register width; fixed at 4 for the opcode set in tap_pkg.
- TCK  in  1  test clock; the only clock. State, IR and bypass update on the rising edge; TDO updates on the falling edge.
- TRST  in  1  reset, synchronous, active-high, sampled on rising TCK.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- BSR_TDO, ID_REG_TDO, USER_REG_TDO  in  1 each  serial outputs of the data-register block.
- CAPTUREDR, SHIFTDR, UPDATEDR  out  1 each  high while the FSM is in Capture-DR, Shift-DR or Update-DR respectively.
- CAPTUREIR, SHIFTIR, UPDATEIR  out  1 each  the IR-side equivalents.
- BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT  out  1 each  one-hot instruction decode.
- TAP_STATE  out  4  current state encoding, for debug.
- TDO  out  1  serial data out.
- TDO_EN  out  1  output enable for TDO.

## Operation
- FSM: the standard 16 states: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, and the IR mirror SEL_IR through UPD_IR.
  - Transitions follow the 1149.1 TMS graph exactly.
  - SEL_IR with TMS=1 goes to TLR.
  - UPD_DR and UPD_IR go to SEL_DR on TMS=1 and to RTI on TMS=0.
- Reset: TRST=1 forces TLR at the next rising edge, regardless of TMS or current state, including mid-shift.
- Five consecutive TMS=1 edges reach TLR from any state without TRST.
- Strobes are Moore-decoded from the state register, so they are glitch-free.
  - The downstream block gates TCK with CAPTUREDR|SHIFTDR, so these must never glitch.
- IR shift register (ir_sh):
  - CAP_IR loads 4'b0101; the LSBs 01 are mandatory.
  - SHIFT_IR does ir_sh <= {TDI, ir_sh[3:1]}; the LSB is shifted out first.
  - Pause and Exit states hold ir_sh.
- Instruction register (ir): loaded from ir_sh on the rising edge that leaves UPD_IR. It is forced to IDCODE while in TLR.
- Opcodes (tap_pkg):
  - EXTEST=0, SAMPLE=1, INTEST=2, RUNBIST=3, CLAMP=4, IDCODE=5, USERCODE=6, HIGHZ=7, BYPASS=F.
  - Any other value decodes to BYPASS.
  - Exactly one *_SELECT is high at all times.
- Bypass bit: loads 0 in CAP_DR. In SHIFT_DR, bypass <= TDI.
- TDO source, retimed on the falling edge of TCK:
  - SHIFT_IR: ir_sh[0].
  - SHIFT_DR with IDCODE: ID_REG_TDO.
  - SHIFT_DR with USERCODE: USER_REG_TDO.
  - SHIFT_DR with EXTEST, SAMPLE or INTEST: BSR_TDO.
  - SHIFT_DR with any other instruction: bypass.
- TDO_EN is high exactly when the falling-edge-sampled state is SHIFT_IR or SHIFT_DR. Otherwise TDO holds its last value.

## Timing
- Reset values:
  - state=TLR, ir=IDCODE (IDCODE_SELECT=1, all other selects 0), ir_sh=4'b0101, bypass=0.
  - TDO=0 and TDO_EN=0 from the next falling edge.
  - All strobes 0.
- Strobe outputs change only after rising TCK edges, one edge after the TMS value that causes the transition.
- A new instruction becomes visible on the *_SELECT lines one rising edge after the UPD_IR state. Selects are stable throughout all DR states.
- The first bit out in a SHIFT_IR or SHIFT_DR shift appears on TDO at the falling edge after entering the shift state.
- Bypass path latency TDI→TDO: one full TCK cycle.
- Simultaneous events:
  - TRST overrides TMS.
  - When TLR and UPD_IR coincide through TRST, TLR wins and ir=IDCODE.

## Structure
- tap_pkg holds the 4-bit state enum (16 named states), the opcode constants, and IR_CAPTURE=4'b0101.
- One sub-module is natural: tap_fsm, the state register, next-state logic and strobe decode.
- The IR, decode, bypass bit and TDO mux live in tap_ctrl.

## Test plan
- From SHIFT_DR with TRST low, hold TMS=1 for 5 edges → state=TLR, IDCODE_SELECT=1, all strobes 0.
- Go to SHIFT_IR and shift TDI=0,0,0,0. The TDO sequence reads 1,0,1,0. After UPD_IR → EXTEST_SELECT=1, others 0.
- Shift in opcode 4'h9 → BYPASS_SELECT=1. In SHIFT_DR, TDI pattern 1,1,0,1 appears on TDO delayed one TCK, preceded by the captured 0.
- IDCODE selected, in SHIFT_DR → TDO tracks ID_REG_TDO each falling edge and TDO_EN=1. In PAUSE_DR → TDO_EN=0, SHIFTDR=0.
- Assert TRST for one edge during SHIFT_IR after 2 bits shifted → next state=TLR, ir=IDCODE, IDCODE_SELECT=1.
- Walk every state with both TMS values → each transition matches the 1149.1 graph, and CAPTUREDR/SHIFTDR/UPDATEDR are high only in their own state.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types and constants for the IEEE 1149.1 TAP controller.
package tap_pkg;

  localparam int unsigned IR_W = 4;

  // Standard 1149.1 state encoding, also exported on TAP_STATE for debug.
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_EXTEST   = 4'h0;
  localparam logic [IR_W-1:0] OP_SAMPLE   = 4'h1;
  localparam logic [IR_W-1:0] OP_INTEST   = 4'h2;
  localparam logic [IR_W-1:0] OP_RUNBIST  = 4'h3;
  localparam logic [IR_W-1:0] OP_CLAMP    = 4'h4;
  localparam logic [IR_W-1:0] OP_IDCODE   = 4'h5;
  localparam logic [IR_W-1:0] OP_USERCODE = 4'h6;
  localparam logic [IR_W-1:0] OP_HIGHZ    = 4'h7;
  localparam logic [IR_W-1:0] OP_BYPASS   = 4'hF;

  // Value captured into the IR shift register; the two LSBs must be 01.
  localparam logic [IR_W-1:0] IR_CAPTURE  = 4'b0101;

  // One-hot instruction select lines.
  typedef struct packed {
    logic bypass;
    logic sample;
    logic extest;
    logic intest;
    logic runbist;
    logic clamp;
    logic idcode;
    logic usercode;
    logic highz;
  } tap_sel_t;

  // Unknown opcodes fall back to BYPASS so exactly one select is always high.
  function automatic tap_sel_t tap_decode(input logic [IR_W-1:0] op);
    tap_sel_t s;
    s = '0;
    case (op)
      OP_EXTEST:   s.extest   = 1'b1;
      OP_SAMPLE:   s.sample   = 1'b1;
      OP_INTEST:   s.intest   = 1'b1;
      OP_RUNBIST:  s.runbist  = 1'b1;
      OP_CLAMP:    s.clamp    = 1'b1;
      OP_IDCODE:   s.idcode   = 1'b1;
      OP_USERCODE: s.usercode = 1'b1;
      OP_HIGHZ:    s.highz    = 1'b1;
      default:     s.bypass   = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: state register, TMS-driven next state, Moore strobes.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  // State register; TRST takes priority over TMS.
  always_ff @(posedge tck_i) begin
    if (trst_i) state_q <= TLR;
    else        state_q <= state_d;
  end

  // 1149.1 TMS transition graph.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = tms_i ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = tms_i ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Strobes decoded only from the state register so they cannot glitch.
  always_comb begin
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    capture_ir_o = 1'b0;
    shift_ir_o   = 1'b0;
    update_ir_o  = 1'b0;
    case (state_q)
      CAP_DR:   capture_dr_o = 1'b1;
      SHIFT_DR: shift_dr_o   = 1'b1;
      UPD_DR:   update_dr_o  = 1'b1;
      CAP_IR:   capture_ir_o = 1'b1;
      SHIFT_IR: shift_ir_o   = 1'b1;
      UPD_IR:   update_ir_o  = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller top: FSM, instruction register, decode, bypass, TDO mux.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH = 4
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BSR_TDO,
  input  logic       ID_REG_TDO,
  input  logic       USER_REG_TDO,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       CAPTUREIR,
  output logic       SHIFTIR,
  output logic       UPDATEIR,
  output logic       BYPASS_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       CLAMP_SELECT,
  output logic       IDCODE_SELECT,
  output logic       USERCODE_SELECT,
  output logic       HIGHZ_SELECT,
  output logic [3:0] TAP_STATE,
  output logic       TDO,
  output logic       TDO_EN
);

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_eff;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_en_q;
  logic                tdo_src;
  tap_sel_t            sel;

  tap_fsm u_fsm (
    .tck_i        (TCK),
    .trst_i       (TRST),
    .tms_i        (TMS),
    .state_o      (state),
    .capture_dr_o (CAPTUREDR),
    .shift_dr_o   (SHIFTDR),
    .update_dr_o  (UPDATEDR),
    .capture_ir_o (CAPTUREIR),
    .shift_ir_o   (SHIFTIR),
    .update_ir_o  (UPDATEIR)
  );

  // Next values for IR shift register, instruction register and bypass bit.
  always_comb begin
    ir_sh_d  = ir_sh_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    case (state)
      CAP_IR:   ir_sh_d  = IR_CAPTURE;
      SHIFT_IR: ir_sh_d  = {TDI, ir_sh_q[IR_WIDTH-1:1]};
      UPD_IR:   ir_d     = ir_sh_q;
      TLR:      ir_d     = OP_IDCODE;
      CAP_DR:   bypass_d = 1'b0;
      SHIFT_DR: bypass_d = TDI;
      default: ;
    endcase
  end

  // Rising-edge registers with synchronous reset.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_sh_q  <= IR_CAPTURE;
      ir_q     <= OP_IDCODE;
      bypass_q <= 1'b0;
    end else begin
      ir_sh_q  <= ir_sh_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
    end
  end

  // TLR overrides the held instruction immediately so IDCODE is selected
  // on the same edge that enters TLR; ir_q itself catches up one edge later.
  always_comb begin
    ir_eff = (state == TLR) ? OP_IDCODE : ir_q;
    sel    = tap_decode(ir_eff);
  end

  // Serial source for TDO.
  always_comb begin
    tdo_src = bypass_q;
    if (state == SHIFT_IR)      tdo_src = ir_sh_q[0];
    else if (sel.idcode)        tdo_src = ID_REG_TDO;
    else if (sel.usercode)      tdo_src = USER_REG_TDO;
    else if (sel.extest || sel.sample || sel.intest) tdo_src = BSR_TDO;
  end

  // Falling-edge retiming of TDO; TLR clears the pin, other non-shift states hold it.
  always_ff @(negedge TCK) begin
    if (state == TLR) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state == SHIFT_IR) || (state == SHIFT_DR);
      if ((state == SHIFT_IR) || (state == SHIFT_DR)) tdo_q <= tdo_src;
    end
  end

  assign BYPASS_SELECT   = sel.bypass;
  assign SAMPLE_SELECT   = sel.sample;
  assign EXTEST_SELECT   = sel.extest;
  assign INTEST_SELECT   = sel.intest;
  assign RUNBIST_SELECT  = sel.runbist;
  assign CLAMP_SELECT    = sel.clamp;
  assign IDCODE_SELECT   = sel.idcode;
  assign USERCODE_SELECT = sel.usercode;
  assign HIGHZ_SELECT    = sel.highz;
  assign TAP_STATE       = state;
  assign TDO             = tdo_q;
  assign TDO_EN          = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed self-checking bench for tap_ctrl.
module tb_tap_ctrl;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6;
  localparam logic [3:0] S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0;
  localparam logic [3:0] S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  // Select vector order: BYPASS,SAMPLE,EXTEST,INTEST,RUNBIST,CLAMP,IDCODE,USERCODE,HIGHZ
  localparam logic [8:0] SL_BYPASS = 9'b100000000, SL_SAMPLE = 9'b010000000;
  localparam logic [8:0] SL_EXTEST = 9'b001000000, SL_INTEST = 9'b000100000;
  localparam logic [8:0] SL_RUNBIST = 9'b000010000, SL_CLAMP = 9'b000001000;
  localparam logic [8:0] SL_IDCODE = 9'b000000100, SL_USER = 9'b000000010;
  localparam logic [8:0] SL_HIGHZ = 9'b000000001;

  logic TCK = 1'b0, TRST = 1'b1, TMS = 1'b1, TDI = 1'b0;
  logic BSR_TDO = 1'b0, ID_REG_TDO = 1'b0, USER_REG_TDO = 1'b0;
  logic CAPTUREDR, SHIFTDR, UPDATEDR, CAPTUREIR, SHIFTIR, UPDATEIR;
  logic BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT;
  logic CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT;
  logic [3:0] TAP_STATE;
  logic TDO, TDO_EN;
  logic [8:0] sel;
  logic [5:0] strb;

  int n_cmp = 0;
  int n_err = 0;

  tap_ctrl #(.IR_WIDTH(4)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .BSR_TDO(BSR_TDO), .ID_REG_TDO(ID_REG_TDO), .USER_REG_TDO(USER_REG_TDO),
    .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .CAPTUREIR(CAPTUREIR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR),
    .BYPASS_SELECT(BYPASS_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
    .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
    .RUNBIST_SELECT(RUNBIST_SELECT), .CLAMP_SELECT(CLAMP_SELECT),
    .IDCODE_SELECT(IDCODE_SELECT), .USERCODE_SELECT(USERCODE_SELECT),
    .HIGHZ_SELECT(HIGHZ_SELECT), .TAP_STATE(TAP_STATE), .TDO(TDO), .TDO_EN(TDO_EN)
  );

  assign sel  = {BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT,
                 CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT};
  assign strb = {CAPTUREDR, SHIFTDR, UPDATEDR, CAPTUREIR, SHIFTIR, UPDATEIR};

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive TMS/TDI, take one rising edge, then the following falling edge.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge TCK); #1;
    @(negedge TCK); #1;
  endtask

  function automatic logic [8:0] exp_sel(input logic [3:0] op);
    case (op)
      4'h0: return SL_EXTEST;
      4'h1: return SL_SAMPLE;
      4'h2: return SL_INTEST;
      4'h3: return SL_RUNBIST;
      4'h4: return SL_CLAMP;
      4'h5: return SL_IDCODE;
      4'h6: return SL_USER;
      4'h7: return SL_HIGHZ;
      default: return SL_BYPASS;
    endcase
  endfunction

  function automatic logic [5:0] exp_strb(input logic [3:0] s);
    return {s == S_CDR, s == S_SHDR, s == S_UDR, s == S_CIR, s == S_SHIR, s == S_UIR};
  endfunction

  // Navigation only: from RTI, shift an opcode in LSB first and return to RTI.
  task automatic load_ir(input logic [3:0] op);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step((i == 3) ? 1'b1 : 1'b0, op[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic test_reset();
    TRST = 1'b1;
    step(1, 0); step(0, 0);
    TRST = 1'b0;
    n_cmp++; if (TAP_STATE !== S_TLR) begin n_err++; $display("FAIL reset_state: got %h want %h", TAP_STATE, S_TLR); end
    n_cmp++; if (sel !== SL_IDCODE) begin n_err++; $display("FAIL reset_sel: got %b want %b", sel, SL_IDCODE); end
    n_cmp++; if (strb !== 6'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 000000", strb); end
    n_cmp++; if (TDO !== 1'b0) begin n_err++; $display("FAIL reset_tdo: got %b want 0", TDO); end
    n_cmp++; if (TDO_EN !== 1'b0) begin n_err++; $display("FAIL reset_tdo_en: got %b want 0", TDO_EN); end
  endtask

  // From TLR: capture 0101, shift zeros, read 1,0,1,0, update to EXTEST.
  task automatic test_ir_shift();
    logic [3:0] exp_tdo;
    exp_tdo = 4'b0101;
    step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    n_cmp++; if (strb !== 6'b000100) begin n_err++; $display("FAIL capir_strobe: got %b want 000100", strb); end
    step(0, 0);
    n_cmp++; if (strb !== 6'b000010) begin n_err++; $display("FAIL shir_strobe: got %b want 000010", strb); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (TDO !== exp_tdo[i] || TDO_EN !== 1'b1) begin
        n_err++; $display("FAIL ir_tdo[%0d]: got %b/en%b want %b/en1", i, TDO, TDO_EN, exp_tdo[i]);
      end
      step((i == 3) ? 1'b1 : 1'b0, 0);
    end
    n_cmp++; if (TAP_STATE !== S_E1IR || TDO_EN !== 1'b0) begin
      n_err++; $display("FAIL ir_exit1: got %h/en%b want %h/en0", TAP_STATE, TDO_EN, S_E1IR);
    end
    step(1, 0);
    n_cmp++; if (strb !== 6'b000001 || sel !== SL_IDCODE) begin
      n_err++; $display("FAIL updir: strobes %b sel %b want 000001 %b", strb, sel, SL_IDCODE);
    end
    step(0, 0);
    n_cmp++; if (sel !== SL_EXTEST) begin n_err++; $display("FAIL extest_sel: got %b want %b", sel, SL_EXTEST); end
  endtask

  // Opcode 9 decodes to BYPASS; TDI shows on TDO one TCK later after a captured 0.
  task automatic test_bypass();
    logic pat [5];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    load_ir(4'h9);
    n_cmp++; if (sel !== SL_BYPASS) begin n_err++; $display("FAIL op9_sel: got %b want %b", sel, SL_BYPASS); end
    step(1, 0); step(0, 0);
    n_cmp++; if (strb !== 6'b100000) begin n_err++; $display("FAIL capdr_strobe: got %b want 100000", strb); end
    step(0, 0);
    n_cmp++; if (TDO !== 1'b0 || TDO_EN !== 1'b1) begin
      n_err++; $display("FAIL byp_capture: got %b/en%b want 0/en1", TDO, TDO_EN);
    end
    for (int i = 0; i < 5; i++) begin
      step((i == 4) ? 1'b1 : 1'b0, pat[i]);
      if (i < 4) begin
        n_cmp++; if (TDO !== pat[i]) begin n_err++; $display("FAIL byp_tdo[%0d]: got %b want %b", i, TDO, pat[i]); end
      end
    end
    n_cmp++; if (TDO_EN !== 1'b0) begin n_err++; $display("FAIL byp_exit_en: got %b want 0", TDO_EN); end
    step(1, 0);
    n_cmp++; if (strb !== 6'b001000) begin n_err++; $display("FAIL upddr_strobe: got %b want 001000", strb); end
    step(0, 0);
  endtask

  // From RTI into SHIFT_DR, then five TMS=1 edges must land in TLR.
  task automatic test_five_tms();
    step(1, 0); step(0, 0); step(0, 0);
    n_cmp++; if (TAP_STATE !== S_SHDR) begin n_err++; $display("FAIL five_start: got %h want %h", TAP_STATE, S_SHDR); end
    for (int i = 0; i < 5; i++) step(1, 0);
    n_cmp++; if (TAP_STATE !== S_TLR) begin n_err++; $display("FAIL five_tlr: got %h want %h", TAP_STATE, S_TLR); end
    n_cmp++; if (sel !== SL_IDCODE) begin n_err++; $display("FAIL five_sel: got %b want %b", sel, SL_IDCODE); end
    n_cmp++; if (strb !== 6'b0) begin n_err++; $display("FAIL five_strobes: got %b want 000000", strb); end
  endtask

  // IDCODE in SHIFT_DR follows ID_REG_TDO; PAUSE_DR disables TDO and holds it.
  task automatic test_idcode();
    logic [3:0] bits;
    bits = 4'b1101;
    step(0, 0); step(1, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      ID_REG_TDO = bits[i]; USER_REG_TDO = ~bits[i]; BSR_TDO = ~bits[i];
      step(0, 0);
      n_cmp++; if (TDO !== bits[i] || TDO_EN !== 1'b1 || sel !== SL_IDCODE) begin
        n_err++; $display("FAIL id_tdo[%0d]: got %b/en%b sel %b want %b/en1", i, TDO, TDO_EN, sel, bits[i]);
      end
    end
    ID_REG_TDO = 1'b0;
    step(1, 0); step(0, 0);
    n_cmp++; if (TAP_STATE !== S_PDR || TDO_EN !== 1'b0 || SHIFTDR !== 1'b0) begin
      n_err++; $display("FAIL pause_dr: state %h en %b shiftdr %b want %h 0 0", TAP_STATE, TDO_EN, SHIFTDR, S_PDR);
    end
    n_cmp++; if (TDO !== 1'b1) begin n_err++; $display("FAIL pause_hold: got %b want 1", TDO); end
    step(1, 0); step(1, 0); step(0, 0);
    ID_REG_TDO = 1'b0; USER_REG_TDO = 1'b0; BSR_TDO = 1'b0;
  endtask

  // USERCODE routes USER_REG_TDO; SAMPLE routes BSR_TDO.
  task automatic test_tdo_mux();
    logic [3:0] ops [2];
    ops = '{4'h6, 4'h1};
    for (int k = 0; k < 2; k++) begin
      load_ir(ops[k]);
      step(1, 0); step(0, 0);
      for (int v = 0; v < 2; v++) begin
        logic tgt;
        tgt = (v == 0);
        if (k == 0) begin USER_REG_TDO = tgt; BSR_TDO = ~tgt; end
        else        begin BSR_TDO = tgt; USER_REG_TDO = ~tgt; end
        ID_REG_TDO = ~tgt;
        step(0, 0);
        n_cmp++; if (TDO !== tgt) begin n_err++; $display("FAIL mux_op%h[%0d]: got %b want %b", ops[k], v, TDO, tgt); end
      end
      step(1, 0); step(1, 0); step(0, 0);
    end
  endtask

  // Every opcode decodes to its one-hot select; undefined ones to BYPASS.
  task automatic test_decode();
    for (int op = 0; op < 16; op++) begin
      load_ir(op[3:0]);
      n_cmp++; if (sel !== exp_sel(op[3:0])) begin
        n_err++; $display("FAIL decode_op%h: got %b want %b", op[3:0], sel, exp_sel(op[3:0]));
      end
    end
  endtask

  // TRST during SHIFT_IR (TMS=0) and during UPD_IR both force TLR and IDCODE.
  task automatic test_trst_cases();
    load_ir(4'h1);
    n_cmp++; if (sel !== SL_SAMPLE) begin n_err++; $display("FAIL trst_pre_sel: got %b want %b", sel, SL_SAMPLE); end
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0);
    TRST = 1'b1; step(0, 0); TRST = 1'b0;
    n_cmp++; if (TAP_STATE !== S_TLR || sel !== SL_IDCODE || strb !== 6'b0) begin
      n_err++; $display("FAIL trst_shift: state %h sel %b strb %b want %h %b 000000", TAP_STATE, sel, strb, S_TLR, SL_IDCODE);
    end
    step(0, 0);
    n_cmp++; if (sel !== SL_IDCODE) begin n_err++; $display("FAIL trst_shift_rti: got %b want %b", sel, SL_IDCODE); end
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step((i == 3) ? 1'b1 : 1'b0, 0);
    step(1, 0);
    n_cmp++; if (TAP_STATE !== S_UIR) begin n_err++; $display("FAIL trst_upd_pre: got %h want %h", TAP_STATE, S_UIR); end
    TRST = 1'b1; step(1, 0); TRST = 1'b0;
    n_cmp++; if (TAP_STATE !== S_TLR || sel !== SL_IDCODE) begin
      n_err++; $display("FAIL trst_upd: state %h sel %b want %h %b", TAP_STATE, sel, S_TLR, SL_IDCODE);
    end
    step(0, 0);
    n_cmp++; if (sel !== SL_IDCODE) begin n_err++; $display("FAIL trst_upd_rti: got %b want %b", sel, SL_IDCODE); end
  endtask

  // Every state with both TMS values against the 1149.1 graph.
  task automatic test_walk();
    string      path [16];
    logic [3:0] st   [16];
    logic [3:0] nx0  [16];
    logic [3:0] nx1  [16];
    string      p;
    path = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
             "01011", "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
    st   = '{S_TLR, S_RTI, S_SDR, S_CDR, S_SHDR, S_E1DR, S_PDR, S_E2DR,
             S_UDR, S_SIR, S_CIR, S_SHIR, S_E1IR, S_PIR, S_E2IR, S_UIR};
    nx0  = '{S_RTI, S_RTI, S_CDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
             S_RTI, S_CIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
    nx1  = '{S_TLR, S_SDR, S_SIR, S_E1DR, S_E1DR, S_UDR, S_E2DR, S_UDR,
             S_SDR, S_TLR, S_E1IR, S_E1IR, S_UIR, S_E2IR, S_UIR, S_SDR};
    for (int k = 0; k < 16; k++) begin
      for (int t = 0; t < 2; t++) begin
        TRST = 1'b1; step(0, 0); TRST = 1'b0;
        p = path[k];
        for (int i = 0; i < p.len(); i++) step(p[i] == "1", 0);
        n_cmp++; if (TAP_STATE !== st[k] || strb !== exp_strb(st[k])) begin
          n_err++; $display("FAIL walk_arrive[%0d]: state %h strb %b want %h %b", k, TAP_STATE, strb, st[k], exp_strb(st[k]));
        end
        step(t[0], 0);
        n_cmp++; if (TAP_STATE !== ((t == 1) ? nx1[k] : nx0[k])) begin
          n_err++; $display("FAIL walk_next[%h,tms%0d]: got %h want %h", st[k], t, TAP_STATE, (t == 1) ? nx1[k] : nx0[k]);
        end
        n_cmp++; if ($countones(sel) != 1) begin n_err++; $display("FAIL walk_onehot[%0d]: got %b want one bit", k, sel); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ir_shift();
    test_bypass();
    test_five_tms();
    test_idcode();
    test_tdo_mux();
    test_decode();
    test_trst_cases();
    test_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
